// File: rtl/s_axil_regbank.sv
// s_axil_regbank: AXI4-Lite slave exposing read/write control and read-only status registers
module s_axil_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int N_CTRL = 8,
  parameter int N_STAT = 8,
  parameter int ADDR_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] CTRL_RESET_VAL = '0
) (
  input  logic                                           axi_clock,
  input  logic                                           rst,
  input  logic [ADDR_WIDTH-1:0]                          s_axil_awaddr,
  input  logic [2:0]                                     s_axil_awprot,
  input  logic                                           s_axil_awvalid,
  output logic                                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]                          s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]                        s_axil_wstrb,
  input  logic                                           s_axil_wvalid,
  output logic                                           s_axil_wready,
  output logic [1:0]                                     s_axil_bresp,
  output logic                                           s_axil_bvalid,
  input  logic                                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]                          s_axil_araddr,
  input  logic [2:0]                                     s_axil_arprot,
  input  logic                                           s_axil_arvalid,
  output logic                                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]                          s_axil_rdata,
  output logic [1:0]                                     s_axil_rresp,
  output logic                                           s_axil_rvalid,
  input  logic                                           s_axil_rready,
  output logic [N_CTRL*DATA_WIDTH-1:0]                   ctrl_regs,
  output logic [N_CTRL-1:0]                              ctrl_wr_pulse,
  input  logic [(N_STAT > 0 ? N_STAT : 1)*DATA_WIDTH-1:0] stat_regs
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int AL = $clog2(SW);
  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [IW-1:0] NC = IW'(N_CTRL);
  localparam logic [IW-1:0] NT = IW'(N_CTRL + N_STAT);
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q, waddr;
  logic [DATA_WIDTH-1:0] w_data_q, wdata, rd_val;
  logic [SW-1:0]         w_strb_q, wstrb;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [IW-1:0]         widx, ridx;
  logic                  unused;
  assign s_axil_awready = !aw_held && !s_axil_bvalid;
  assign s_axil_wready  = !w_held && !s_axil_bvalid;
  assign s_axil_arready = !s_axil_rvalid;
  assign aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_hs   = s_axil_wvalid && s_axil_wready;
  assign ar_hs  = s_axil_arvalid && s_axil_arready;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);
  assign waddr  = aw_held ? aw_addr_q : s_axil_awaddr;
  assign wdata  = w_held ? w_data_q : s_axil_wdata;
  assign wstrb  = w_held ? w_strb_q : s_axil_wstrb;
  assign widx   = {1'b0, waddr >> AL};
  assign ridx   = {1'b0, s_axil_araddr >> AL};
  assign unused = ^{s_axil_awprot, s_axil_arprot};
  // Read mux: control value, live status value, or zero when unmapped
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < N_CTRL; k++)
      if (ridx == IW'(k)) rd_val = ctrl_regs[k*DATA_WIDTH +: DATA_WIDTH];
    for (int k = 0; k < N_STAT; k++)
      if (ridx == IW'(N_CTRL + k)) rd_val = stat_regs[k*DATA_WIDTH +: DATA_WIDTH];
  end
  // Capture AW and W payloads so either may arrive first
  always_ff @(posedge axi_clock) begin
    if (aw_hs) aw_addr_q <= s_axil_awaddr;
    if (w_hs) begin
      w_data_q <= s_axil_wdata;
      w_strb_q <= s_axil_wstrb;
    end
  end
  // Write handshake tracking and B response
  always_ff @(posedge axi_clock)
    if (rst) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= 2'b00;
    end else if (commit) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      s_axil_bvalid <= 1'b1;
      s_axil_bresp  <= widx < NC ? 2'b00 : 2'b10;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs) w_held <= 1'b1;
      if (s_axil_bready) s_axil_bvalid <= 1'b0;
    end
  // Control registers: byte-lane update plus one-cycle write strobe
  always_ff @(posedge axi_clock)
    if (rst) begin
      ctrl_regs     <= {N_CTRL{CTRL_RESET_VAL}};
      ctrl_wr_pulse <= '0;
    end else begin
      ctrl_wr_pulse <= '0;
      for (int k = 0; k < N_CTRL; k++)
        if (commit && widx == IW'(k)) begin
          ctrl_wr_pulse[k] <= 1'b1;
          for (int b = 0; b < SW; b++)
            if (wstrb[b]) ctrl_regs[k*DATA_WIDTH + b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end
  // Read response: register data at AR handshake, hold until accepted
  always_ff @(posedge axi_clock)
    if (rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= 2'b00;
    end else if (ar_hs) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_val;
      s_axil_rresp  <= ridx < NT ? 2'b00 : 2'b10;
    end else if (s_axil_rready) s_axil_rvalid <= 1'b0;
endmodule

// File: tb/tb_s_axil_regbank.sv
// tb_s_axil_regbank: directed and randomized checks of the AXI-Lite register bank
module tb_s_axil_regbank;
  localparam int DW = 32;
  localparam int NC = 8;
  localparam int NS = 8;
  localparam int AW = 12;
  localparam logic [DW-1:0] RV = 32'hA5A5_0F0F;
  logic axi_clock = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] s_axil_awaddr = '0, s_axil_araddr = '0;
  logic [2:0] s_axil_awprot = '0, s_axil_arprot = '0;
  logic s_axil_awvalid = 1'b0, s_axil_wvalid = 1'b0, s_axil_bready = 1'b0;
  logic s_axil_arvalid = 1'b0, s_axil_rready = 1'b0;
  logic [DW-1:0] s_axil_wdata = '0;
  logic [DW/8-1:0] s_axil_wstrb = '0;
  logic s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0] s_axil_bresp, s_axil_rresp;
  logic [DW-1:0] s_axil_rdata;
  logic [NC*DW-1:0] ctrl_regs;
  logic [NC-1:0] ctrl_wr_pulse;
  logic [NS*DW-1:0] stat_regs;
  logic [DW-1:0] m_ctrl [NC];
  logic [DW-1:0] m_stat [NS];
  int checks = 0;
  int failures = 0;

  s_axil_regbank #(.DATA_WIDTH(DW), .N_CTRL(NC), .N_STAT(NS), .ADDR_WIDTH(AW), .CTRL_RESET_VAL(RV)) dut (
    .axi_clock(axi_clock), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse), .stat_regs(stat_regs)
  );

  always #5 axi_clock = ~axi_clock;

  for (genvar g = 0; g < NS; g++) begin : g_stat
    assign stat_regs[g*DW +: DW] = m_stat[g];
  end

  task automatic tick;
    @(posedge axi_clock);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < NC; k++) m_ctrl[k] = RV;
    checks++;
    if (s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1 || s_axil_arready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: aw=%b w=%b ar=%b expected 111", s_axil_awready, s_axil_wready, s_axil_arready);
    end
    checks++;
    if (s_axil_bvalid !== 1'b0 || s_axil_rvalid !== 1'b0 || s_axil_bresp !== 2'b00 || s_axil_rresp !== 2'b00 || s_axil_rdata !== '0) begin
      failures++;
      $display("FAIL reset_resp: bv=%b rv=%b bresp=%b rresp=%b rdata=%h expected 0 0 00 00 0", s_axil_bvalid, s_axil_rvalid, s_axil_bresp, s_axil_rresp, s_axil_rdata);
    end
    checks++;
    if (ctrl_wr_pulse !== '0) begin
      failures++;
      $display("FAIL reset_pulse: got %b expected 0", ctrl_wr_pulse);
    end
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (ctrl_regs[k*DW +: DW] !== RV) begin
        failures++;
        $display("FAIL reset_ctrl%0d: got %h expected %h", k, ctrl_regs[k*DW +: DW], RV);
      end
    end
  endtask

  task automatic test_same_cycle;
    s_axil_awaddr = 12'h004; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'hDEADBEEF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    m_ctrl[1] = 32'hDEADBEEF;
    checks++;
    if (ctrl_regs[1*DW +: DW] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL same_cycle_reg1: got %h expected deadbeef", ctrl_regs[1*DW +: DW]);
    end
    checks++;
    if (ctrl_wr_pulse !== 8'h02) begin
      failures++;
      $display("FAIL same_cycle_pulse: got %b expected 00000010", ctrl_wr_pulse);
    end
    checks++;
    if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00 || s_axil_awready !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_b: bv=%b bresp=%b awready=%b expected 1 00 0", s_axil_bvalid, s_axil_bresp, s_axil_awready);
    end
    tick();
    s_axil_bready = 1'b0;
    checks++;
    if (ctrl_wr_pulse !== '0 || s_axil_bvalid !== 1'b0 || s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_after: pulse=%b bv=%b aw=%b w=%b expected 0 0 1 1", ctrl_wr_pulse, s_axil_bvalid, s_axil_awready, s_axil_wready);
    end
  endtask

  task automatic test_w_before_aw;
    s_axil_awaddr = 12'h000; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    tick();
    checks++;
    if (ctrl_regs[0 +: DW] !== 32'h12345678) begin
      failures++;
      $display("FAIL wfirst_setup: got %h expected 12345678", ctrl_regs[0 +: DW]);
    end
    s_axil_wdata = 32'h000000AA; s_axil_wstrb = 4'h1; s_axil_wvalid = 1'b1;
    tick();
    s_axil_wvalid = 1'b0;
    checks++;
    if (s_axil_wready !== 1'b0 || s_axil_awready !== 1'b1 || s_axil_bvalid !== 1'b0 || ctrl_regs[0 +: DW] !== 32'h12345678) begin
      failures++;
      $display("FAIL wfirst_held: wready=%b awready=%b bv=%b reg0=%h expected 0 1 0 12345678", s_axil_wready, s_axil_awready, s_axil_bvalid, ctrl_regs[0 +: DW]);
    end
    tick();
    tick();
    s_axil_awaddr = 12'h000; s_axil_awvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0;
    m_ctrl[0] = 32'h123456AA;
    checks++;
    if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00 || ctrl_wr_pulse !== 8'h01 || ctrl_regs[0 +: DW] !== 32'h123456AA) begin
      failures++;
      $display("FAIL wfirst_commit: bv=%b bresp=%b pulse=%b reg0=%h expected 1 00 00000001 123456aa", s_axil_bvalid, s_axil_bresp, ctrl_wr_pulse, ctrl_regs[0 +: DW]);
    end
    tick();
    s_axil_bready = 1'b0;
    checks++;
    if (s_axil_wready !== 1'b1 || s_axil_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL wfirst_release: wready=%b bv=%b expected 1 0", s_axil_wready, s_axil_bvalid);
    end
  endtask

  task automatic test_rready_hold;
    m_stat[0] = 32'h00C0FFEE;
    s_axil_araddr = 12'(NC*4); s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    tick();
    s_axil_arvalid = 1'b0;
    m_stat[0] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'h00C0FFEE || s_axil_rresp !== 2'b00 || s_axil_arready !== 1'b0) begin
        failures++;
        $display("FAIL rhold_cycle%0d: rv=%b rdata=%h rresp=%b arready=%b expected 1 00c0ffee 00 0", i, s_axil_rvalid, s_axil_rdata, s_axil_rresp, s_axil_arready);
      end
      if (i < 4) tick();
    end
    s_axil_rready = 1'b1;
    tick();
    s_axil_rready = 1'b0;
    checks++;
    if (s_axil_rvalid !== 1'b0 || s_axil_arready !== 1'b1) begin
      failures++;
      $display("FAIL rhold_release: rv=%b arready=%b expected 0 1", s_axil_rvalid, s_axil_arready);
    end
  endtask

  task automatic test_errors;
    s_axil_awaddr = 12'(NC*4); s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'hFFFFFFFF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    checks++;
    if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b10 || ctrl_wr_pulse !== '0) begin
      failures++;
      $display("FAIL err_write: bv=%b bresp=%b pulse=%b expected 1 10 0", s_axil_bvalid, s_axil_bresp, ctrl_wr_pulse);
    end
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (ctrl_regs[k*DW +: DW] !== m_ctrl[k]) begin
        failures++;
        $display("FAIL err_ctrl%0d: got %h expected %h", k, ctrl_regs[k*DW +: DW], m_ctrl[k]);
      end
    end
    tick();
    s_axil_bready = 1'b0;
    s_axil_araddr = 12'((NC+NS)*4); s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    tick();
    s_axil_arvalid = 1'b0;
    checks++;
    if (s_axil_rvalid !== 1'b1 || s_axil_rresp !== 2'b10 || s_axil_rdata !== '0) begin
      failures++;
      $display("FAIL err_read: rv=%b rresp=%b rdata=%h expected 1 10 0", s_axil_rvalid, s_axil_rresp, s_axil_rdata);
    end
    tick();
    s_axil_rready = 1'b0;
    checks++;
    if (s_axil_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL err_read_release: rv=%b expected 0", s_axil_rvalid);
    end
  endtask

  task automatic test_reset_inflight;
    s_axil_awaddr = 12'h008; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h11112222; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1; s_axil_bready = 1'b0;
    tick();
    s_axil_wvalid = 1'b0;
    s_axil_awaddr = 12'h00C;
    tick();
    checks++;
    if (s_axil_bvalid !== 1'b1 || s_axil_awready !== 1'b0) begin
      failures++;
      $display("FAIL inflight_pending: bv=%b awready=%b expected 1 0", s_axil_bvalid, s_axil_awready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_axil_awvalid = 1'b0;
    for (int k = 0; k < NC; k++) m_ctrl[k] = RV;
    checks++;
    if (s_axil_bvalid !== 1'b0 || s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1 || s_axil_arready !== 1'b1) begin
      failures++;
      $display("FAIL inflight_reset: bv=%b aw=%b w=%b ar=%b expected 0 1 1 1", s_axil_bvalid, s_axil_awready, s_axil_wready, s_axil_arready);
    end
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (ctrl_regs[k*DW +: DW] !== RV) begin
        failures++;
        $display("FAIL inflight_ctrl%0d: got %h expected %h", k, ctrl_regs[k*DW +: DW], RV);
      end
    end
    s_axil_awaddr = 12'h004; s_axil_awvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_axil_wdata = 32'h33334444; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
    tick();
    s_axil_wvalid = 1'b0;
    tick();
    checks++;
    if (s_axil_bvalid !== 1'b0 || s_axil_wready !== 1'b0 || ctrl_regs[1*DW +: DW] !== RV) begin
      failures++;
      $display("FAIL inflight_aw_dropped: bv=%b wready=%b reg1=%h expected 0 0 %h", s_axil_bvalid, s_axil_wready, ctrl_regs[1*DW +: DW], RV);
    end
    s_axil_bready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    int wr_left = 80, rd_left = 80, cyc = 0, last_commit = -10, last_ar = -10, w_idx = 0, r_idx = 0;
    bit w_active = 0, aw_vld = 0, w_vld = 0, aw_done = 0, w_done = 0, aw_hs = 0, w_hs = 0, ar_vld = 0, ar_hs = 0;
    logic [DW-1:0] w_data = '0;
    logic [3:0] w_strb = '0;
    logic [NC-1:0] exp_pulse;
    logic [NC*DW-1:0] exp_ctrl;
    logic [33:0] rexp;
    logic [1:0] bq [$];
    logic [33:0] rq [$];
    while ((wr_left > 0 || rd_left > 0 || w_active || ar_vld || bq.size() > 0 || rq.size() > 0) && cyc < 20000) begin
      exp_pulse = '0;
      if (aw_hs) begin aw_done = 1; aw_vld = 0; end
      if (w_hs) begin w_done = 1; w_vld = 0; end
      if (w_active && aw_done && w_done) begin
        checks++;
        if (cyc - last_commit < 2) begin
          failures++;
          $display("FAIL rnd_write_rate: commits %0d cycles apart, required at least 2", cyc - last_commit);
        end
        last_commit = cyc;
        if (w_idx < NC) begin
          for (int b = 0; b < 4; b++) if (w_strb[b]) m_ctrl[w_idx][b*8 +: 8] = w_data[b*8 +: 8];
          exp_pulse[w_idx] = 1'b1;
        end
        bq.push_back(w_idx < NC ? 2'b00 : 2'b10);
        w_active = 0;
      end
      if (ar_hs) begin
        ar_vld = 0;
        checks++;
        if (cyc - last_ar < 2) begin
          failures++;
          $display("FAIL rnd_read_rate: reads %0d cycles apart, required at least 2", cyc - last_ar);
        end
        last_ar = cyc;
      end
      for (int k = 0; k < NC; k++) exp_ctrl[k*DW +: DW] = m_ctrl[k];
      checks++;
      if (ctrl_wr_pulse !== exp_pulse) begin
        failures++;
        $display("FAIL rnd_pulse cyc%0d: got %b expected %b", cyc, ctrl_wr_pulse, exp_pulse);
      end
      checks++;
      if (ctrl_regs !== exp_ctrl) begin
        failures++;
        $display("FAIL rnd_ctrl cyc%0d: got %h expected %h", cyc, ctrl_regs, exp_ctrl);
      end
      s_axil_bready = 1'b0;
      if (s_axil_bvalid === 1'b1) begin
        checks++;
        if (bq.size() == 0) begin
          failures++;
          $display("FAIL rnd_spurious_b cyc%0d: bvalid=1 expected 0", cyc);
        end else if ($urandom % 3 != 0) begin
          s_axil_bready = 1'b1;
          if (s_axil_bresp !== bq[0]) begin
            failures++;
            $display("FAIL rnd_bresp cyc%0d: got %b expected %b", cyc, s_axil_bresp, bq[0]);
          end
          void'(bq.pop_front());
        end
      end
      s_axil_rready = 1'b0;
      if (s_axil_rvalid === 1'b1) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL rnd_spurious_r cyc%0d: rvalid=1 expected 0", cyc);
        end else if ($urandom % 3 != 0) begin
          s_axil_rready = 1'b1;
          if ({s_axil_rresp, s_axil_rdata} !== rq[0]) begin
            failures++;
            $display("FAIL rnd_rdata cyc%0d: got %b/%h expected %b/%h", cyc, s_axil_rresp, s_axil_rdata, rq[0][33:32], rq[0][31:0]);
          end
          void'(rq.pop_front());
        end
      end
      if (!w_active && wr_left > 0 && $urandom % 2 == 0) begin
        w_idx = ($urandom % 4 != 0) ? int'($urandom_range(0, NC-1)) : int'($urandom_range(NC, NC+NS+3));
        w_data = $urandom;
        w_strb = 4'($urandom);
        w_active = 1; aw_done = 0; w_done = 0;
        s_axil_awaddr = 12'(w_idx*4 + int'($urandom % 4));
        s_axil_wdata = w_data;
        s_axil_wstrb = w_strb;
        wr_left--;
      end
      if (w_active && !aw_done && !aw_vld && $urandom % 2 == 0) aw_vld = 1;
      if (w_active && !w_done && !w_vld && $urandom % 2 == 0) w_vld = 1;
      s_axil_awvalid = aw_vld;
      s_axil_wvalid = w_vld;
      aw_hs = aw_vld && s_axil_awready === 1'b1;
      w_hs = w_vld && s_axil_wready === 1'b1;
      if ($urandom % 4 == 0) m_stat[$urandom % NS] = $urandom;
      if (!ar_vld && rd_left > 0 && $urandom % 2 == 0) begin
        r_idx = ($urandom % 5 != 0) ? int'($urandom_range(0, NC+NS-1)) : int'($urandom_range(NC+NS, NC+NS+3));
        s_axil_araddr = 12'(r_idx*4 + int'($urandom % 4));
        ar_vld = 1;
        rd_left--;
      end
      s_axil_arvalid = ar_vld;
      ar_hs = ar_vld && s_axil_arready === 1'b1;
      if (ar_hs) begin
        if (r_idx < NC) rexp = {2'b00, m_ctrl[r_idx]};
        else if (r_idx < NC+NS) rexp = {2'b00, m_stat[r_idx-NC]};
        else rexp = {2'b10, 32'h0};
        rq.push_back(rexp);
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc >= 20000) begin
      failures++;
      $display("FAIL rnd_timeout: ran %0d cycles, limit 20000 with bq=%0d rq=%0d pending", cyc, bq.size(), rq.size());
    end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NS; k++) m_stat[k] = '0;
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_rready_hold();
    test_errors();
    test_reset_inflight();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
